ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Arbitrates the single-port program/data RAM between the CPU control path and an external program loader/debug port. The CPU owns the RAM by default. When the loader requests the RAM, the block holds the CPU via its HALT input and waits for the CPU bus to drain. It then grants the loader one-word read/write accesses and returns ownership to the CPU on release. It sits between CPULogic's RAM strobes and the RAM primitive, and advances only on SLOW_CLOCK_STRB.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 10, RAM word width (matches full opcode width)
- DRAIN_CNT, 4, consecutive idle strobes required before granting the loader (covers the CPU's 3-stage HALT synchronizer plus 1)

Ports:
- CLK  in  1  system clock; all state changes on the rising edge
- ARST  in  1  asynchronous, active-high reset
- SLOW_CLOCK_STRB  in  1  step enable; the FSM, counters and captures advance only when it is 1
- cpu_ram_in / cpu_ram_out / cpu_ram_wr  in  1 each  CPU address-load, read and write strobes
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_hold  out  1  to the CPU HALT input
- ld_req  in  1  loader wants ownership (level)
- ld_valid  in  1  loader access request, sampled in GRANT
- ld_we  in  1  1 = write, 0 = read
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader owns the RAM
- ld_ack  out  1  one-CLK pulse when a loader access completes
- ld_rdata  out  DATA_W  read data captured at ack
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_in / ram_out / ram_wr  out  1 each  RAM strobes
- ram_rdata  in  DATA_W  RAM read data
- conflict  out  1  sticky error flag; set if the CPU strobes while the loader is granted

## Operation
States: CPU_OWN, DRAIN, GRANT, ACCESS, RELEASE. Reset state is CPU_OWN.

- CPU_OWN
  - RAM outputs are a combinational pass-through of the cpu_* signals.
  - ld_req=1 → DRAIN; cpu_hold=1 from that edge onward.
- DRAIN
  - cpu_hold=1; pass-through continues.
  - The drain counter increments each strobe in which all three CPU strobes are 0.
  - Any CPU strobe clears the counter.
  - Counter reaching DRAIN_CNT → GRANT.
  - ld_req=0 → RELEASE; the counter clears.
- GRANT
  - cpu_hold=1, ld_gnt=1; RAM outputs are 0 (addr/wdata are don't-care, driven 0).
  - ld_valid=1 → ACCESS. The same edge captures ld_addr, ld_wdata and ld_we into hold registers.
  - ld_req=0 (with ld_valid=0) → RELEASE.
  - ld_valid=1 takes priority over ld_req=0.
- ACCESS
  - Drives ram_addr and ram_wdata from the hold registers.
  - ram_in=1. Read: ram_out=1. Write: ram_wr=1.
  - The next strobe edge captures ram_rdata into ld_rdata (reads only; writes leave ld_rdata unchanged), pulses ld_ack for exactly 1 CLK, and returns to GRANT.
  - An access in progress always completes, even if ld_req drops.
- RELEASE
  - ld_gnt=0, cpu_hold=1 for one strobe, then → CPU_OWN with cpu_hold=0.
- Conflict detection: any cpu_ram_* = 1 in GRANT, ACCESS or RELEASE
  - sets conflict;
  - the CPU strobe is not forwarded to the RAM.
  - conflict clears only on ARST.

## Timing
- Reset values: cpu_hold=0, ld_gnt=0, ld_ack=0, ld_rdata=0, conflict=0, drain counter=0, hold registers=0.
- RAM outputs follow the CPU inputs combinationally (reset state is CPU_OWN).
- ARST mid-operation: immediate return to CPU_OWN. Any in-flight loader access is abandoned with no ack.
- ld_req to ld_gnt: minimum DRAIN_CNT+1 strobes (1 to enter DRAIN, then DRAIN_CNT idle strobes).
- Loader access: ld_valid sampled at strobe N; RAM strobes active during strobe period N..N+1; ld_ack and ld_rdata valid after strobe N+1. One access per 2 strobes.
- ld_req fall (GRANT) to cpu_hold fall: 2 strobes.
- Strobe-gating: with SLOW_CLOCK_STRB=0 on a CLK edge, nothing changes except that ld_ack returns to 0.
- Counter width: ceil(log2(DRAIN_CNT+1)); the counter saturates at DRAIN_CNT.

## Test plan
- Pass-through
  - Stimulus: CPU-only traffic, ld_req=0, cpu_addr=0x3C, cpu_ram_wr=1, cpu_wdata=0x2A5.
  - Response: ram_addr=0x3C, ram_wr=1, ram_wdata=0x2A5 in the same cycle; cpu_hold=0.
- Drain restart
  - Stimulus: ld_req=1; CPU strobes ram_out on idle strobe 2.
  - Response: counter restarts; ld_gnt rises only after 4 further idle strobes.
- Loader write then read
  - Stimulus: write 0x155 to 0x10; read 0x10 with the RAM model returning the stored word.
  - Response: ld_ack pulses twice; ld_rdata=0x155; each access takes 2 strobes.
- Release mid-access
  - Stimulus: ld_req drops in ACCESS.
  - Response: ack still issued; RELEASE for 1 strobe; cpu_hold=0 two strobes after the ack.
- Conflict
  - Stimulus: force cpu_ram_wr=1 during GRANT.
  - Response: ram_wr stays 0; conflict=1 and persists until ARST.
- Async reset
  - Stimulus: pulse ARST during ACCESS, with no strobe.
  - Response: ld_gnt=0, cpu_hold=0, ld_ack never asserts; RAM outputs return to pass-through.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Hands the single-port RAM from the CPU to an external loader/debug port once the CPU bus has drained.
// Latency: ld_req to ld_gnt in DRAIN_CNT+1 strobes; each loader access completes (ld_ack) on the strobe after it is sampled.
module ram_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 10,
  parameter int DRAIN_CNT = 4
) (
  input  logic              CLK,
  input  logic              ARST,
  input  logic              SLOW_CLOCK_STRB,
  input  logic              cpu_ram_in,
  input  logic              cpu_ram_out,
  input  logic              cpu_ram_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_hold,
  input  logic              ld_req,
  input  logic              ld_valid,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_in,
  output logic              ram_out,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              conflict
);

  localparam int CW = (DRAIN_CNT < 1) ? 1 : $clog2(DRAIN_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_CNT);

  typedef enum logic [2:0] {
    CPU_OWN,
    DRAIN,
    GRANT,
    ACCESS,
    RELEASE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [CW-1:0]     w_cnt_inc;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_conflict;
  logic              w_cpu_any;
  logic              w_ld_owned;

  assign w_cpu_any  = cpu_ram_in | cpu_ram_out | cpu_ram_wr;
  assign w_ld_owned = (r_state == GRANT) || (r_state == ACCESS) || (r_state == RELEASE);
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      CPU_OWN: begin
        if (ld_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!ld_req) begin
          w_state_nxt = RELEASE;
        end else if (!w_cpu_any) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_MAX) w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        // A pending access wins over a simultaneous release request.
        if (ld_valid)     w_state_nxt = ACCESS;
        else if (!ld_req) w_state_nxt = RELEASE;
      end
      ACCESS:  w_state_nxt = GRANT;
      RELEASE: w_state_nxt = CPU_OWN;
      default: w_state_nxt = CPU_OWN;
    endcase
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      r_state    <= CPU_OWN;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_ack <= SLOW_CLOCK_STRB && (r_state == ACCESS);
      if (SLOW_CLOCK_STRB) begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        if ((r_state == GRANT) && ld_valid) begin
          r_addr  <= ld_addr;
          r_wdata <= ld_wdata;
          r_we    <= ld_we;
        end
        if ((r_state == ACCESS) && !r_we) r_rdata <= ram_rdata;
        if (w_ld_owned && w_cpu_any) r_conflict <= 1'b1;
      end
    end
  end

  // CPU strobes reach the RAM only while the CPU still owns the bus.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_in    = 1'b0;
    ram_out   = 1'b0;
    ram_wr    = 1'b0;
    case (r_state)
      CPU_OWN, DRAIN: begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_in    = cpu_ram_in;
        ram_out   = cpu_ram_out;
        ram_wr    = cpu_ram_wr;
      end
      ACCESS: begin
        ram_addr  = r_addr;
        ram_wdata = r_wdata;
        ram_in    = 1'b1;
        ram_out   = !r_we;
        ram_wr    = r_we;
      end
      default: ;
    endcase
  end

  assign cpu_hold = (r_state != CPU_OWN);
  assign ld_gnt   = (r_state == GRANT) || (r_state == ACCESS);
  assign ld_ack   = r_ack;
  assign ld_rdata = r_rdata;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 256x10 RAM model.
module tb_ram_port_arbiter;

  logic       CLK = 1'b0;
  logic       ARST = 1'b1;
  logic       SLOW_CLOCK_STRB = 1'b0;
  logic       cpu_ram_in = 1'b0, cpu_ram_out = 1'b0, cpu_ram_wr = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [9:0] cpu_wdata = '0;
  logic       cpu_hold;
  logic       ld_req = 1'b0, ld_valid = 1'b0, ld_we = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [9:0] ld_wdata = '0;
  logic       ld_gnt, ld_ack;
  logic [9:0] ld_rdata;
  logic [7:0] ram_addr;
  logic [9:0] ram_wdata;
  logic       ram_in, ram_out, ram_wr;
  logic [9:0] ram_rdata;
  logic       conflict;

  int total = 0;
  int bad   = 0;

  logic [9:0] mem [256];

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(10), .DRAIN_CNT(4)) dut (
    .CLK(CLK), .ARST(ARST), .SLOW_CLOCK_STRB(SLOW_CLOCK_STRB),
    .cpu_ram_in(cpu_ram_in), .cpu_ram_out(cpu_ram_out), .cpu_ram_wr(cpu_ram_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_hold(cpu_hold),
    .ld_req(ld_req), .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_in(ram_in), .ram_out(ram_out),
    .ram_wr(ram_wr), .ram_rdata(ram_rdata), .conflict(conflict)
  );

  always #5 CLK = ~CLK;

  assign ram_rdata = mem[ram_addr];
  always @(posedge CLK) begin
    if (SLOW_CLOCK_STRB && ram_wr) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge with the strobe high; inputs change and outputs are read 1ns after the edge.
  task automatic stb();
    SLOW_CLOCK_STRB = 1'b1;
    @(posedge CLK);
    #1;
    SLOW_CLOCK_STRB = 1'b0;
  endtask

  task automatic idle_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    idle_clk(2);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_gnt", ld_gnt, 0);
    chk("rst_ack", ld_ack, 0);
    chk("rst_rdata", ld_rdata, 0);
    chk("rst_conflict", conflict, 0);
    ARST = 1'b0;
    idle_clk(1);

    // Pass-through
    cpu_addr = 8'h3C; cpu_ram_wr = 1'b1; cpu_wdata = 10'h2A5;
    #1;
    chk("pt_addr", ram_addr, 8'h3C);
    chk("pt_wr", ram_wr, 1);
    chk("pt_wdata", ram_wdata, 10'h2A5);
    chk("pt_hold", cpu_hold, 0);
    stb();
    chk("pt_hold_after_stb", cpu_hold, 0);
    cpu_ram_wr = 1'b0;

    // Drain restart, with strobe-less clocks that must not advance the counter
    ld_req = 1'b1;
    stb();
    chk("drain_hold", cpu_hold, 1);
    chk("drain_gnt", ld_gnt, 0);
    stb();
    cpu_ram_out = 1'b1; cpu_addr = 8'h07;
    #1;
    chk("drain_pt_out", ram_out, 1);
    stb();
    cpu_ram_out = 1'b0;
    stb(); stb(); stb();
    idle_clk(3);
    chk("drain_gnt_early", ld_gnt, 0);
    stb();
    chk("drain_gnt_rise", ld_gnt, 1);
    chk("grant_ram_out", ram_out, 0);

    // Loader write 0x155 -> 0x10
    ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 8'h10; ld_wdata = 10'h155;
    stb();
    ld_valid = 1'b0; ld_addr = 8'hEE; ld_wdata = 10'h3FF;
    #1;
    chk("wr_ram_addr", ram_addr, 8'h10);
    chk("wr_ram_wdata", ram_wdata, 10'h155);
    chk("wr_strobes", {ram_in, ram_out, ram_wr}, 3'b101);
    chk("wr_ack_early", ld_ack, 0);
    stb();
    chk("wr_ack", ld_ack, 1);
    chk("wr_rdata_unchanged", ld_rdata, 0);
    idle_clk(1);
    chk("wr_ack_one_clk", ld_ack, 0);

    // Loader read back 0x10
    ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 8'h10;
    stb();
    ld_valid = 1'b0;
    chk("rd_strobes", {ram_in, ram_out, ram_wr}, 3'b110);
    chk("rd_ram_addr", ram_addr, 8'h10);
    stb();
    chk("rd_ack", ld_ack, 1);
    chk("rd_rdata", ld_rdata, 10'h155);

    // Release mid-access: read 0x3C (written by the CPU earlier)
    ld_valid = 1'b1; ld_addr = 8'h3C;
    stb();
    ld_valid = 1'b0; ld_req = 1'b0;
    stb();
    chk("rel_ack", ld_ack, 1);
    chk("rel_rdata", ld_rdata, 10'h2A5);
    chk("rel_hold_at_ack", cpu_hold, 1);
    stb();
    chk("rel_gnt", ld_gnt, 0);
    chk("rel_hold_release", cpu_hold, 1);
    stb();
    chk("rel_hold_fall", cpu_hold, 0);

    // Conflict during GRANT
    ld_req = 1'b1;
    for (int i = 0; i < 5; i++) stb();
    chk("cf_gnt", ld_gnt, 1);
    cpu_ram_wr = 1'b1; cpu_addr = 8'h20;
    #1;
    chk("cf_ram_wr_blocked", ram_wr, 0);
    stb();
    chk("cf_set", conflict, 1);
    cpu_ram_wr = 1'b0; ld_req = 1'b0;
    stb(); stb();
    chk("cf_back_cpu", cpu_hold, 0);
    chk("cf_sticky", conflict, 1);

    // Async reset during ACCESS, no strobe
    ld_req = 1'b1;
    for (int i = 0; i < 5; i++) stb();
    ld_valid = 1'b1; ld_we = 1'b0; ld_addr = 8'h10;
    stb();
    ld_valid = 1'b0;
    chk("ar_in_access", ram_in, 1);
    #1 ARST = 1'b1;
    #1;
    chk("ar_gnt", ld_gnt, 0);
    chk("ar_hold", cpu_hold, 0);
    chk("ar_conflict_clr", conflict, 0);
    ARST = 1'b0; ld_req = 1'b0;
    cpu_ram_in = 1'b1; cpu_addr = 8'h55;
    #1;
    chk("ar_pt_in", ram_in, 1);
    chk("ar_pt_addr", ram_addr, 8'h55);
    stb();
    chk("ar_no_ack1", ld_ack, 0);
    stb();
    chk("ar_no_ack2", ld_ack, 0);
    chk("ar_hold_after", cpu_hold, 0);
    cpu_ram_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
